// File: rtl/rom_dl_router.sv
`default_nettype none
// ============================================================================
// Module   : rom_dl_router
// Brief    : Routes ioctl download bytes to sdram write ports 1/2 with a toggle
//            req/ack handshake. Also tracks the byte count, the checksum and
//            the load-complete flag.
// Revision : 1.0 - initial release
// ============================================================================
module rom_dl_router #(
    parameter logic [7:0]  ROM_INDEX = 8'd0,
    parameter logic [16:0] SP_BASE   = 17'h10000,
    parameter logic [16:0] SP_END    = 17'h1BFFF,
    parameter logic [16:0] ROM_SIZE  = 17'h1C320
) (
    input  logic        clk_mem,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic [15:0] port1_d,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [22:0] port2_a,
    output logic [1:0]  port2_ds,
    output logic [15:0] port2_d,
    output logic [16:0] byte_count,
    output logic [15:0] checksum,
    output logic        rom_loaded
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_wr_d;
    logic        r_dl_d;
    logic        r_ack1_s;
    logic        r_ack2_s;
    logic        r_use2;
    logic        r_eval_pend;
    logic [24:0] r_addr;
    logic [7:0]  r_data;

    logic        w_wr_rise;
    logic        w_dl_rise;
    logic        w_dl_fall;
    logic        w_accept;
    logic        w_in_sprite;
    logic [23:0] w_off;
    logic        w_done;
    logic [16:0] w_count_next;
    logic        w_size_ok;

    assign w_wr_rise   = ioctl_wr & ~r_wr_d;
    assign w_dl_rise   = ioctl_download & ~r_dl_d;
    assign w_dl_fall   = ~ioctl_download & r_dl_d;
    assign w_accept    = w_wr_rise & ioctl_download & (ioctl_index == ROM_INDEX);

    // Anything with bits above the 17-bit ROM space set is never a sprite byte.
    assign w_in_sprite = (r_addr[24:17] == 8'd0) &&
                         (r_addr[16:0] >= SP_BASE) &&
                         (r_addr[16:0] <= SP_END);
    assign w_off       = r_addr[23:0] - {7'd0, SP_BASE};

    assign w_done       = (r_ack1_s == port1_req) &&
                          (!r_use2 || (r_ack2_s == port2_req));
    assign w_count_next = (byte_count == 17'h1FFFF) ? byte_count : byte_count + 17'd1;
    assign w_size_ok    = (byte_count >= ROM_SIZE);

    always_ff @(posedge clk_mem) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wr_d      <= 1'b0;
            r_dl_d      <= 1'b0;
            r_ack1_s    <= 1'b0;
            r_ack2_s    <= 1'b0;
            r_use2      <= 1'b0;
            r_eval_pend <= 1'b0;
            r_addr      <= 25'd0;
            r_data      <= 8'd0;
            ioctl_wait  <= 1'b0;
            port1_req   <= 1'b0;
            port1_a     <= 23'd0;
            port1_ds    <= 2'b00;
            port1_d     <= 16'd0;
            port2_req   <= 1'b0;
            port2_a     <= 23'd0;
            port2_ds    <= 2'b00;
            port2_d     <= 16'd0;
            byte_count  <= 17'd0;
            checksum    <= 16'd0;
            rom_loaded  <= 1'b0;
        end else begin
            r_wr_d   <= ioctl_wr;
            r_dl_d   <= ioctl_download;
            r_ack1_s <= port1_ack;
            r_ack2_s <= port2_ack;

            // Strobes arriving outside IDLE are dropped, never queued.
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr     <= ioctl_addr;
                        r_data     <= ioctl_dout;
                        ioctl_wait <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    port1_a   <= r_addr[23:1];
                    port1_ds  <= {r_addr[0], ~r_addr[0]};
                    port1_d   <= {r_data, r_data};
                    port1_req <= ~port1_req;
                    r_use2    <= w_in_sprite;
                    if (w_in_sprite) begin
                        port2_a   <= {w_off[23:16], w_off[13:0], w_off[15]};
                        port2_ds  <= {w_off[14], ~w_off[14]};
                        port2_d   <= {r_data, r_data};
                        port2_req <= ~port2_req;
                    end
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_done) begin
                        byte_count <= w_count_next;
                        checksum   <= checksum + {8'd0, r_data};
                        ioctl_wait <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // A byte in flight at download end must commit before the size test.
            if (w_dl_fall) begin
                if (r_state == S_IDLE) begin
                    rom_loaded <= w_size_ok;
                end else begin
                    r_eval_pend <= 1'b1;
                end
            end else if (r_eval_pend && (r_state == S_IDLE)) begin
                rom_loaded  <= w_size_ok;
                r_eval_pend <= 1'b0;
            end

            if (w_dl_rise) begin
                byte_count  <= 17'd0;
                checksum    <= 16'd0;
                rom_loaded  <= 1'b0;
                r_eval_pend <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
